// File: rtl/csa_product_resolver_pkg.sv
// Shared constants for the significand product resolver and the normaliser behind it.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package csa_product_resolver_pkg;

  localparam int CSA_SIG_WIDTH = 23;                      // stored significand width
  localparam int CSA_CHUNK     = 13;                      // adder bits resolved per cycle
  localparam int CSA_W         = 2*CSA_SIG_WIDTH + 6;     // resolve width
  localparam int CSA_NCHUNK    = (CSA_W + CSA_CHUNK - 1) / CSA_CHUNK;

  // Resolver FSM encodings, shared so the normaliser can decode them too.
  typedef enum logic [1:0] {
    CSA_IDLE = 2'd0,
    CSA_ADD  = 2'd1,
    CSA_DONE = 2'd2
  } csa_state_e;

endpackage

// File: rtl/csa_product_resolver_cpa_chunk.sv
// CHUNK-bit carry-propagate adder slice with carry in and carry out.
// Latency: combinational.
// Backpressure: none; the caller sequences it.
module cpa_chunk #(
  parameter int CHUNK = 13
) (
  input  logic [CHUNK-1:0] i_a,
  input  logic [CHUNK-1:0] i_b,
  input  logic             i_cin,
  output logic [CHUNK-1:0] o_sum,
  output logic             o_cout
);

  assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {{CHUNK{1'b0}}, i_cin};

endmodule

// File: rtl/csa_product_resolver.sv
// Resolves a carry-save (sum, carry) product into a binary product, CHUNK bits per cycle.
// Latency: pair accepted on edge T, out_valid high from edge T+NCHUNK; one op in flight.
// Backpressure: result held in DONE until out_ready; a new pair is taken on the same edge.
module csa_product_resolver
  import csa_product_resolver_pkg::*;
#(
  parameter int SIG_WIDTH = CSA_SIG_WIDTH,
  parameter int CHUNK     = CSA_CHUNK
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2*SIG_WIDTH+3:0] sum,
  input  logic [2*SIG_WIDTH+3:0] carry,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2*SIG_WIDTH+1:0] prod,
  output logic                   prod_msb,
  output logic                   ovf
);

  localparam int SW     = 2*SIG_WIDTH + 4;             // carry-save vector width
  localparam int PW     = 2*SIG_WIDTH + 2;             // product width
  localparam int W      = 2*SIG_WIDTH + 6;             // resolve width
  localparam int NCHUNK = (W + CHUNK - 1) / CHUNK;
  localparam int PADW   = NCHUNK * CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  csa_state_e        r_state;
  csa_state_e        w_state_nxt;
  logic [PADW-1:0]   r_a;
  logic [PADW-1:0]   r_b;
  logic [PADW-1:0]   r_res;
  logic [IDX_W-1:0]  r_idx;
  logic              r_cy;
  logic [PW-1:0]     r_prod;
  logic              r_msb;
  logic              r_ovf;
  logic              r_out_valid;

  logic              w_in_ready;
  logic              w_accept;
  logic              w_last;
  logic [W-1:0]      w_a;
  logic [W-1:0]      w_b;
  logic [PADW-1:0]   w_a_pad;
  logic [PADW-1:0]   w_b_pad;
  logic [CHUNK-1:0]  w_chunk_sum;
  logic              w_cout;
  logic [PADW-1:0]   w_res_nxt;

  // Operand A is the sign-extended sum; B is the sign-extended carry at weight x2.
  assign w_a     = {sum[SW-1], sum[SW-1], sum};
  assign w_b     = {carry[SW-1], carry, 1'b0};
  assign w_a_pad = PADW'(w_a);
  assign w_b_pad = PADW'(w_b);

  // Operands are shifted down one chunk per cycle, so the adder always sees the low chunk.
  cpa_chunk #(
    .CHUNK (CHUNK)
  ) u_cpa_chunk (
    .i_a    (r_a[CHUNK-1:0]),
    .i_b    (r_b[CHUNK-1:0]),
    .i_cin  (r_cy),
    .o_sum  (w_chunk_sum),
    .o_cout (w_cout)
  );

  // Result chunks enter at the top; after NCHUNK steps chunk 0 sits at bit 0.
  assign w_res_nxt = {w_chunk_sum, r_res[PADW-1:CHUNK]};
  assign w_last    = (r_idx == IDX_W'(NCHUNK - 1));
  assign w_accept  = in_valid & w_in_ready;

  // Next-state and handshake decode.
  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    case (r_state)
      CSA_IDLE: begin
        w_in_ready = 1'b1;
        if (in_valid) w_state_nxt = CSA_ADD;
      end
      CSA_ADD: begin
        if (w_last) w_state_nxt = CSA_DONE;
      end
      CSA_DONE: begin
        w_in_ready = out_ready;
        if (out_ready) w_state_nxt = in_valid ? CSA_ADD : CSA_IDLE;
      end
      default: w_state_nxt = CSA_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= CSA_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Operand latch, chunk iteration and result capture; the last carry-out is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a         <= '0;
      r_b         <= '0;
      r_res       <= '0;
      r_idx       <= '0;
      r_cy        <= 1'b0;
      r_prod      <= '0;
      r_msb       <= 1'b0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= (w_state_nxt == CSA_DONE);
      if (w_accept) begin
        r_a   <= w_a_pad;
        r_b   <= w_b_pad;
        r_cy  <= 1'b0;
        r_idx <= '0;
      end else if (r_state == CSA_ADD) begin
        r_a   <= r_a >> CHUNK;
        r_b   <= r_b >> CHUNK;
        r_res <= w_res_nxt;
        r_cy  <= w_cout;
        r_idx <= r_idx + IDX_W'(1);
        if (w_last) begin
          r_prod <= w_res_nxt[PW-1:0];
          r_msb  <= w_res_nxt[PW-1];
          r_ovf  <= |w_res_nxt[W-1:PW];
        end
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign prod      = r_prod;
  assign prod_msb  = r_msb;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_csa_product_resolver.sv
// Self-checking bench for csa_product_resolver with a queue-based scoreboard.
// Latency: checks out_valid arrives 4 cycles after each accept.
// Backpressure: holds out_ready low and checks result stability and same-edge re-accept.
module tb_csa_product_resolver;

  typedef struct packed {
    logic [47:0] prod;
    logic        msb;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [49:0] sum = '0;
  logic [49:0] carry = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [47:0] prod;
  logic        prod_msb;
  logic        ovf;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  exp_t q[$];

  csa_product_resolver dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sum       (sum),
    .carry     (carry),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .prod      (prod),
    .prod_msb  (prod_msb),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: sign-extended sum plus sign-extended carry at weight 2, modulo 2^52.
  function automatic exp_t model(input logic [49:0] s, input logic [49:0] c);
    logic [51:0] r;
    exp_t        e;
    r      = {{2{s[49]}}, s} + {c[49], c, 1'b0};
    e.prod = r[47:0];
    e.msb  = r[47];
    e.ovf  = |r[51:48];
    return e;
  endfunction

  function automatic logic [49:0] rnd50();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[49:0];
  endfunction

  // Present a pair and hold it until accepted; t_acc is the accept edge.
  task automatic send_pair(input logic [49:0] s, input logic [49:0] c, output int t_acc);
    bit ok;
    ok       = 1'b0;
    sum      = s;
    carry    = c;
    in_valid = 1'b1;
    #1;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (in_ready) ok = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    t_acc    = cyc;
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL send_accept in_ready never seen, got=%0b want=1", in_ready);
    end
  endtask

  // Wait (bounded) for out_valid; t_out is the edge it was first seen after.
  task automatic wait_out(output int t_out);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (out_valid) ok = 1'b1;
      else begin @(posedge clk); #1; end
    end
    t_out = cyc;
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL out_valid_timeout got=%0b want=1", out_valid);
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid  = 1'($urandom());
      out_ready = 1'($urandom());
      sum       = rnd50();
      carry     = rnd50();
      @(posedge clk); #1;
      total++;
      if (out_valid !== 1'b0 || prod !== 48'h0 || ovf !== 1'b0 || prod_msb !== 1'b0) begin
        bad++;
        $display("FAIL reset_outputs got v=%0b p=%h o=%0b m=%0b want 0 0 0 0",
                 out_valid, prod, ovf, prod_msb);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst_n     = 1'b1;
    @(posedge clk); #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_in_ready got=%0b want=1", in_ready);
    end
  endtask

  task automatic test_directed();
    logic [49:0] vs [8];
    logic [49:0] vc [8];
    exp_t        ve [8];
    exp_t        e;
    int          ta, to;
    // multiplier vectors, plain and split across sum/carry
    vs[0] = 50'h0400000000000; vc[0] = 50'h0;             ve[0] = {48'h4000_0000_0000, 1'b0, 1'b0};
    vs[1] = 50'h03FFFFFFFFFFE; vc[1] = 50'h1;             ve[1] = {48'h4000_0000_0000, 1'b0, 1'b0};
    vs[2] = 50'h0FFFFFE000001; vc[2] = 50'h0;             ve[2] = {48'hFFFF_FE00_0001, 1'b1, 1'b0};
    vs[3] = 50'h0FFFFFE000003; vc[3] = 50'h3FFFFFFFFFFFF; ve[3] = {48'hFFFF_FE00_0001, 1'b1, 1'b0};
    // chunk-boundary carry
    vs[4] = 50'h1FFF;          vc[4] = 50'h1;             ve[4] = {48'h2001, 1'b0, 1'b0};
    // sign handling and overflow
    vs[5] = 50'h3FFFFFFFFFFFF; vc[5] = 50'h1;             ve[5] = {48'h1, 1'b0, 1'b0};
    vs[6] = 50'h1000000000000; vc[6] = 50'h0;             ve[6] = {48'h0, 1'b0, 1'b1};
    vs[7] = 50'h0;             vc[7] = 50'h0;             ve[7] = {48'h0, 1'b0, 1'b0};
    for (int i = 0; i < 8; i++) begin
      q.push_back(ve[i]);
      send_pair(vs[i], vc[i], ta);
      wait_out(to);
      e = q.pop_front();
      total++;
      if (to - ta != 4) begin
        bad++;
        $display("FAIL directed%0d_latency got=%0d want=4", i, to - ta);
      end
      total++;
      if (prod !== e.prod || prod_msb !== e.msb || ovf !== e.ovf) begin
        bad++;
        $display("FAIL directed%0d_result got p=%h m=%0b o=%0b want p=%h m=%0b o=%0b",
                 i, prod, prod_msb, ovf, e.prod, e.msb, e.ovf);
      end
      consume();
    end
  endtask

  task automatic test_random();
    logic [49:0] s, c;
    exp_t        e;
    int          ta, to;
    for (int i = 0; i < 10; i++) begin
      s = rnd50();
      c = rnd50();
      if (i < 5) begin
        s[49:46] = '0;
        c[49:45] = '0;
      end
      q.push_back(model(s, c));
      send_pair(s, c, ta);
      wait_out(to);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      e = q.pop_front();
      total++;
      if (prod !== e.prod || prod_msb !== e.msb || ovf !== e.ovf) begin
        bad++;
        $display("FAIL random%0d got p=%h m=%0b o=%0b want p=%h m=%0b o=%0b",
                 i, prod, prod_msb, ovf, e.prod, e.msb, e.ovf);
      end
      consume();
    end
  endtask

  task automatic test_backpressure();
    logic [49:0] s2, c2;
    exp_t        e;
    int          ta, to;
    q.push_back(model(50'h0123456789ABC, 50'h0000FEDCBA987));
    send_pair(50'h0123456789ABC, 50'h0000FEDCBA987, ta);
    wait_out(to);
    e = q.pop_front();
    for (int i = 0; i < 5; i++) begin
      total++;
      if (out_valid !== 1'b1 || prod !== e.prod || ovf !== e.ovf || in_ready !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold%0d got v=%0b p=%h o=%0b r=%0b want v=1 p=%h o=%0b r=0",
                 i, out_valid, prod, ovf, in_ready, e.prod, e.ovf);
      end
      @(posedge clk); #1;
    end
    s2 = 50'h0000000ABCDEF;
    c2 = 50'h0000000012345;
    q.push_back(model(s2, c2));
    sum       = s2;
    carry     = c2;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_in_ready_follows got=%0b want=1", in_ready);
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    ta        = cyc;
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL bp_drop_valid got=%0b want=0", out_valid);
    end
    wait_out(to);
    e = q.pop_front();
    total++;
    if (to - ta != 4) begin
      bad++;
      $display("FAIL bp_latency got=%0d want=4", to - ta);
    end
    total++;
    if (prod !== e.prod || ovf !== e.ovf || prod_msb !== e.msb) begin
      bad++;
      $display("FAIL bp_second got p=%h o=%0b want p=%h o=%0b", prod, ovf, e.prod, e.ovf);
    end
    consume();
  endtask

  task automatic test_abort();
    exp_t e;
    int   ta, to, seen;
    send_pair(50'h0FFFFFE000001, 50'h0, ta);
    @(posedge clk); #1;            // now in the 2nd ADD cycle
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    seen  = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid) seen++;
      @(posedge clk); #1;
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL abort_no_valid got=%0d cycles valid want=0", seen);
    end
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL abort_in_ready got=%0b want=1", in_ready);
    end
    q.push_back({48'h5, 1'b0, 1'b0});
    send_pair(50'h5, 50'h0, ta);
    wait_out(to);
    e = q.pop_front();
    total++;
    if (prod !== e.prod || ovf !== e.ovf || to - ta != 4) begin
      bad++;
      $display("FAIL abort_next got p=%h o=%0b lat=%0d want p=%h o=%0b lat=4",
               prod, ovf, to - ta, e.prod, e.ovf);
    end
    consume();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_abort();
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_leftover got=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete, got timeout want finish");
    $fatal(1);
  end

endmodule
